int_mul_var_n: RTL and testbench

- Parametrised, variable-latency iterative integer multiplier.
- Produces the full 2*NBITS product for either signed or unsigned operands, selected per transaction.
- Each cycle skips up to MAX_SHIFT trailing zero bits of the multiplier.
- Val/rdy stream block; drop-in successor wherever full-width or signed products are needed, e.g. mulh-style ops in the processor execute stage.

---
 rtl/int_mul_var_pkg.sv | 32 +++
 rtl/int_mul_var_shamt.sv | 28 ++
 rtl/int_mul_var_n.sv | 173 +++++++++++++++++
 tb/tb_int_mul_var_n.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/int_mul_var_pkg.sv
// Shared types and constants for the variable-latency iterative multiplier.
package int_mul_var_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // a_reg load select
  localparam logic [1:0] A_HOLD  = 2'd0;
  localparam logic [1:0] A_LOAD  = 2'd1;
  localparam logic [1:0] A_SHIFT = 2'd2;

  // b_reg load select
  localparam logic [1:0] B_HOLD  = 2'd0;
  localparam logic [1:0] B_LOAD  = 2'd1;
  localparam logic [1:0] B_SHIFT = 2'd2;

  // result load select
  localparam logic [1:0] R_HOLD  = 2'd0;
  localparam logic [1:0] R_CLEAR = 2'd1;
  localparam logic [1:0] R_ADD   = 2'd2;
  localparam logic [1:0] R_FIX   = 2'd3;

  // Shift amount must hold values 0..max_shift inclusive.
  function automatic int shamt_width(input int max_shift);
    return $clog2(max_shift) + 1;
  endfunction

endpackage

// File: rtl/int_mul_var_shamt.sv
// Per-cycle shift amount: trailing-zero count of the low MAX_SHIFT bits of
// the multiplier, saturating at MAX_SHIFT; 1 when bit 0 is set (add + shift).
module int_mul_var_shamt
  import int_mul_var_pkg::*;
#(
  parameter int MAX_SHIFT = 8,
  parameter int SW        = shamt_width(MAX_SHIFT)
) (
  input  logic [MAX_SHIFT-1:0] b_low,
  output logic [SW-1:0]        shamt
);

  logic found;

  // Priority search from bit 0 for the first set bit.
  always_comb begin
    shamt = SW'(MAX_SHIFT);
    found = 1'b0;
    for (int i = 0; i < MAX_SHIFT; i++) begin
      if (!found && b_low[i]) begin
        shamt = SW'(i);
        found = 1'b1;
      end
    end
    if (b_low[0]) shamt = SW'(1);
  end

endmodule

// File: rtl/int_mul_var_n.sv
// Variable-latency iterative multiplier, full 2*NBITS product, signed or
// unsigned per transaction. Skips up to MAX_SHIFT zero multiplier bits per cycle.
// Build option: INT_MUL_VAR_ZERO_FAST_EN sends zero-operand requests straight
// to DONE (result 0, response the cycle after accept).
//
//   state | meaning
//   IDLE  | ready for a request
//   CALC  | add/shift over multiplier bits until b_reg is zero
//   FIX   | apply sign to the magnitude product
//   DONE  | response valid, waiting for ostream_rdy
module int_mul_var_n
  import int_mul_var_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int MAX_SHIFT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [NBITS-1:0] istream_a,
  input  logic [NBITS-1:0] istream_b,
  input  logic             istream_signed,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [NBITS-1:0] ostream_lo,
  output logic [NBITS-1:0] ostream_hi
);

  localparam int SW = shamt_width(MAX_SHIFT);
  localparam int PW = 2 * NBITS;

  state_t           state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [PW-1:0]    res_q, res_d;
  logic             neg_q, neg_d;
  logic             rdy_q, rdy_d;
  logic             val_q, val_d;
  logic [NBITS-1:0] lo_q, lo_d;
  logic [NBITS-1:0] hi_q, hi_d;

  logic [1:0]       a_sel, b_sel, r_sel;
  logic             neg_ld;
  logic [SW-1:0]    shamt;
  logic [NBITS-1:0] a_mag, b_mag;
  logic             istream_go, ostream_go;

  assign istream_rdy = rdy_q;
  assign ostream_val = val_q;
  assign ostream_lo  = lo_q;
  assign ostream_hi  = hi_q;
  assign istream_go  = istream_val & istream_rdy;
  assign ostream_go  = ostream_val & ostream_rdy;

  // Operand magnitudes; negating the most negative value wraps to itself,
  // which is the correct unsigned magnitude.
  assign a_mag = (istream_signed && istream_a[NBITS-1]) ? -istream_a : istream_a;
  assign b_mag = (istream_signed && istream_b[NBITS-1]) ? -istream_b : istream_b;

  int_mul_var_shamt #(.MAX_SHIFT(MAX_SHIFT), .SW(SW)) u_shamt (
    .b_low (b_q[MAX_SHIFT-1:0]),
    .shamt (shamt)
  );

  // ---------------- ctrl ----------------
  // state   | a_sel   b_sel   r_sel   next
  // IDLE go | LOAD    LOAD    CLEAR   CALC (DONE on zero operand, fast build)
  // CALC b=0| HOLD    HOLD    HOLD    FIX
  // CALC b!0| SHIFT   SHIFT   ADD if b[0] else HOLD
  // FIX     | HOLD    HOLD    FIX     DONE
  // DONE    | HOLD    HOLD    HOLD    IDLE on ostream_go
  // Next-state and control-signal decode.
  always_comb begin
    state_d = state_q;
    a_sel   = A_HOLD;
    b_sel   = B_HOLD;
    r_sel   = R_HOLD;
    neg_ld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (istream_go) begin
          a_sel  = A_LOAD;
          b_sel  = B_LOAD;
          r_sel  = R_CLEAR;
          neg_ld = 1'b1;
`ifdef INT_MUL_VAR_ZERO_FAST_EN
          if ((istream_a == '0) || (istream_b == '0)) state_d = DONE;
          else                                        state_d = CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        if (b_q == '0) begin
          state_d = FIX;
        end else begin
          a_sel = A_SHIFT;
          b_sel = B_SHIFT;
          if (b_q[0]) r_sel = R_ADD;
        end
      end
      FIX: begin
        r_sel   = R_FIX;
        state_d = DONE;
      end
      DONE: begin
        if (ostream_go) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        a_sel   = 'x;
        b_sel   = 'x;
        r_sel   = 'x;
        neg_ld  = 1'bx;
      end
    endcase
  end

  // ---------------- dpath ----------------
  // Register next values from the control selects; outputs are registered
  // and forced to zero whenever the next state is not DONE.
  always_comb begin
    case (a_sel)
      A_LOAD:  a_d = PW'(a_mag);
      A_SHIFT: a_d = a_q << shamt;
      default: a_d = a_q;
    endcase
    case (b_sel)
      B_LOAD:  b_d = b_mag;
      B_SHIFT: b_d = b_q >> shamt;
      default: b_d = b_q;
    endcase
    case (r_sel)
      R_CLEAR: res_d = '0;
      R_ADD:   res_d = res_q + a_q;
      R_FIX:   res_d = neg_q ? -res_q : res_q;
      default: res_d = res_q;
    endcase
    neg_d = neg_ld ? (istream_signed & (istream_a[NBITS-1] ^ istream_b[NBITS-1])) : neg_q;
    rdy_d = (state_d == IDLE);
    val_d = (state_d == DONE);
    lo_d  = val_d ? res_d[NBITS-1:0] : '0;
    hi_d  = val_d ? res_d[PW-1:NBITS] : '0;
  end

  // State and datapath flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      rdy_q   <= 1'b1;
      val_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      rdy_q   <= rdy_d;
      val_q   <= val_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: tb/tb_int_mul_var_n.sv
// Self-checking bench for int_mul_var_n (NBITS=32, MAX_SHIFT=8).
module tb_int_mul_var_n;

  localparam int NB = 32;
  localparam int MS = 8;

  logic          clk;
  logic          reset;
  logic          istream_val;
  logic          istream_rdy;
  logic [NB-1:0] istream_a;
  logic [NB-1:0] istream_b;
  logic          istream_signed;
  logic          ostream_val;
  logic          ostream_rdy;
  logic [NB-1:0] ostream_lo;
  logic [NB-1:0] ostream_hi;

  int n_asrt = 0;
  int n_fail = 0;

  int_mul_var_n #(.NBITS(NB), .MAX_SHIFT(MS)) dut (
    .clk            (clk),
    .reset          (reset),
    .istream_val    (istream_val),
    .istream_rdy    (istream_rdy),
    .istream_a      (istream_a),
    .istream_b      (istream_b),
    .istream_signed (istream_signed),
    .ostream_val    (ostream_val),
    .ostream_rdy    (ostream_rdy),
    .ostream_lo     (ostream_lo),
    .ostream_hi     (ostream_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact mathematical product, truncated to 64 bits.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Edges between the accept edge and first observation of ostream_val.
  function automatic int ref_wait(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint unsigned m;
    int steps, tz;
    m = (s && b[31]) ? longint'(64'(-$signed({32'd0, b}) ) & 64'hFFFF_FFFF) : longint'(b);
    if (s && b[31]) m = longint'(33'h1_0000_0000 - {1'b0, b});
`ifdef INT_MUL_VAR_ZERO_FAST_EN
    if (a == 0 || b == 0) return 0;
`endif
    steps = 0;
    while (m != 0) begin
      if (m % 2 == 1) m = m / 2;
      else begin
        tz = 0;
        while (tz < MS && ((m >> tz) % 2 == 0)) tz++;
        m = m >> tz;
      end
      steps++;
    end
    return steps + 2;  // steps + zero-detect cycle + FIX cycle
  endfunction

  logic [63:0] exp_p;
  logic [NB-1:0] hold_lo, hold_hi;

  // Present one request and wait for the response (ostream_rdy left to caller).
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    int n;
    chk({tag, "_in_rdy"}, {63'd0, istream_rdy}, 64'd1);
    istream_val = 1'b1; istream_a = a; istream_b = b; istream_signed = s;
    @(posedge clk); #1;
    istream_val = 1'b0;
    exp_p = ref_prod(a, b, s);
    n = 0;
    while (!ostream_val && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(ref_wait(a, b, s)));
    chk({tag, "_lo"}, {32'd0, ostream_lo}, {32'd0, exp_p[31:0]});
    chk({tag, "_hi"}, {32'd0, ostream_hi}, {32'd0, exp_p[63:32]});
    chk({tag, "_busy"}, {63'd0, istream_rdy}, 64'd0);
  endtask

  // Complete the response handshake and check return to idle.
  task automatic drain(input string tag);
    ostream_rdy = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_val_clr"}, {63'd0, ostream_val}, 64'd0);
    chk({tag, "_lo_clr"}, {32'd0, ostream_lo}, 64'd0);
    chk({tag, "_idle_rdy"}, {63'd0, istream_rdy}, 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    reset = 1'b1; istream_val = 1'b0; istream_a = '0; istream_b = '0;
    istream_signed = 1'b0; ostream_rdy = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", {63'd0, istream_rdy}, 64'd1);
    chk("rst_val", {63'd0, ostream_val}, 64'd0);
    chk("rst_lo",  {32'd0, ostream_lo}, 64'd0);
    chk("rst_hi",  {32'd0, ostream_hi}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    send(32'd3, 32'd4, 1'b0, "u3x4");                      drain("u3x4");
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax");      drain("umax");
    send(32'hFFFF_FFFE, 32'd3, 1'b1, "sm2x3");             drain("sm2x3");
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "sm1xm1");    drain("sm1xm1");
    send(32'h8000_0000, 32'h8000_0000, 1'b1, "sminsq");    drain("sminsq");
    send(32'd1, 32'h8000_0000, 1'b0, "skip");              drain("skip");
    send(32'd12345, 32'd0, 1'b0, "bzero");                 drain("bzero");
    send(32'd0, 32'h0000_00F1, 1'b1, "azero");             drain("azero");

    // Backpressure: hold response for 5 cycles, then accept next request at once.
    ostream_rdy = 1'b0;
    send(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, "bp");
    hold_lo = ostream_lo; hold_hi = ostream_hi;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_val_hold", {63'd0, ostream_val}, 64'd1);
      chk("bp_lo_hold", {32'd0, ostream_lo}, {32'd0, exp_p[31:0]});
      chk("bp_hi_hold", {32'd0, ostream_hi}, {32'd0, exp_p[63:32]});
      chk("bp_in_rdy", {63'd0, istream_rdy}, 64'd0);
    end
    ostream_rdy = 1'b1;
    @(posedge clk); #1;
    send(32'd9, 32'd11, 1'b0, "bp_next");                  drain("bp_next");

    // Reset in the middle of CALC discards the transaction.
    istream_val = 1'b1; istream_a = 32'd1; istream_b = 32'h8000_0000; istream_signed = 1'b0;
    @(posedge clk); #1;
    istream_val = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_rdy", {63'd0, istream_rdy}, 64'd1);
    chk("mid_rst_val", {63'd0, ostream_val}, 64'd0);
    chk("mid_rst_lo",  {32'd0, ostream_lo}, 64'd0);
    chk("mid_rst_hi",  {32'd0, ostream_hi}, 64'd0);
    send(32'd5, 32'd7, 1'b0, "post_rst");
    chk("post_rst_35", {32'd0, ostream_lo}, 64'd35);
    drain("post_rst");

    // Random operands, sign mode and occasional zero or extreme values.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: ra = '0;
        1: rb = '0;
        2: rb = rb & 32'h0000_00FF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      send(ra, rb, rs, "rand");
      drain("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
